// File: rtl/exc_redirect_ctrl.sv
// Exception/ERET sequencer: flushes the pipe, updates or reads EPC over
// the shared CP0 port, and redirects IF. Grants ID mfc0 reads when idle.
module exc_redirect_ctrl #(
  parameter logic [31:0] EX_VEC   = 32'hbfc00380,
  parameter logic [4:0]  EPC_ADDR = 5'd14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_ex,
  input  logic        ws_eret,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic        mfc0_req,
  input  logic [4:0]  mfc0_raddr,
  output logic        mfc0_gnt,
  output logic        mfc0_rvalid,
  output logic [31:0] mfc0_rdata,
  output logic [4:0]  cp0_raddr,
  input  logic [31:0] cp0_rdata,
  output logic        cp0_we,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    EX_WR,
    ERET_RD,
    REDIRECT
  } state_t;

  state_t state;
  logic   idle;

  assign idle = (state == IDLE);

  // reset gating keeps the grant low while the async reset is held
  assign mfc0_gnt = ~reset & mfc0_req & idle & ~ws_ex & ~ws_eret;

  always_comb begin
    cp0_raddr = 5'd31;
    if (mfc0_gnt)
      cp0_raddr = mfc0_raddr;
    else if (state == ERET_RD)
      cp0_raddr = EPC_ADDR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      flush          <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      cp0_we         <= 1'b0;
      cp0_waddr      <= 5'd31;
      cp0_wdata      <= 32'd0;
      mfc0_rvalid    <= 1'b0;
      mfc0_rdata     <= 32'd0;
    end else begin
      mfc0_rvalid <= mfc0_gnt;
      if (mfc0_gnt)
        mfc0_rdata <= cp0_rdata;
      unique case (state)
        IDLE: begin
          if (ws_ex) begin
            state     <= EX_WR;
            flush     <= 1'b1;
            busy      <= 1'b1;
            cp0_we    <= 1'b1;
            cp0_waddr <= EPC_ADDR;
            // EPC points at the branch when the fault sits in its slot
            cp0_wdata <= ws_bd ? ws_pc - 32'd4 : ws_pc;
          end else if (ws_eret) begin
            state <= ERET_RD;
            flush <= 1'b1;
            busy  <= 1'b1;
          end
        end
        EX_WR: begin
          state          <= REDIRECT;
          cp0_we         <= 1'b0;
          cp0_waddr      <= 5'd31;
          cp0_wdata      <= 32'd0;
          redirect_pc    <= EX_VEC;
          redirect_valid <= 1'b1;
        end
        ERET_RD: begin
          state          <= REDIRECT;
          redirect_pc    <= cp0_rdata;
          redirect_valid <= 1'b1;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed plus random checks of exc_redirect_ctrl against a
// cycle-level behavioural model and a fake CP0 register file.
module tb_exc_redirect_ctrl;

  localparam logic [31:0] EXV = 32'hbfc00380;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_ex, ws_eret, ws_bd;
  logic [31:0] ws_pc;
  logic        mfc0_req;
  logic [4:0]  mfc0_raddr;
  logic        mfc0_gnt, mfc0_rvalid;
  logic [31:0] mfc0_rdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        flush, redirect_valid, busy;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  logic [31:0] cp0_regs [32];
  logic        seed, poke;
  logic [4:0]  poke_a;
  logic [31:0] poke_d;

  int total = 0;
  int passed = 0;

  // model state: 0 idle, 1 EPC write, 2 EPC read, 3 redirecting
  int          ph;
  logic [31:0] m_wdata, m_rpc, m_rdata;
  logic        m_prev_gnt;

  always #5 clk = ~clk;

  exc_redirect_ctrl dut (
    .clk(clk), .reset(reset),
    .ws_ex(ws_ex), .ws_eret(ws_eret), .ws_pc(ws_pc), .ws_bd(ws_bd),
    .mfc0_req(mfc0_req), .mfc0_raddr(mfc0_raddr),
    .mfc0_gnt(mfc0_gnt), .mfc0_rvalid(mfc0_rvalid),
    .mfc0_rdata(mfc0_rdata),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .busy(busy)
  );

  assign cp0_rdata = cp0_regs[cp0_raddr];

  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 32; i++) cp0_regs[i] <= $urandom;
    end else if (cp0_we) begin
      cp0_regs[cp0_waddr] <= cp0_wdata;
    end else if (poke) begin
      cp0_regs[poke_a] <= poke_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // drive one cycle (called #1 after a posedge), check at negedge
  task automatic step(input logic r, input logic ex, input logic er,
                      input logic [31:0] pc, input logic bd,
                      input logic rq, input logic [4:0] ra,
                      input logic rdy);
    logic        e_gnt, e_we, e_rv, e_bsy, e_rvalid;
    logic [4:0]  e_raddr, e_waddr;
    logic [31:0] e_wdata, e_rpc, e_rdata;
    reset = r; ws_ex = ex; ws_eret = er; ws_pc = pc; ws_bd = bd;
    mfc0_req = rq; mfc0_raddr = ra; redirect_ready = rdy;
    @(negedge clk);
    if (r) begin
      e_gnt = 0; e_we = 0; e_rv = 0; e_bsy = 0; e_rvalid = 0;
      e_raddr = 31; e_waddr = 31; e_wdata = 0; e_rpc = 0; e_rdata = 0;
    end else begin
      e_bsy    = (ph != 0);
      e_gnt    = rq && ph == 0 && !ex && !er;
      e_raddr  = e_gnt ? ra : (ph == 2 ? 5'd14 : 5'd31);
      e_we     = (ph == 1);
      e_waddr  = (ph == 1) ? 5'd14 : 5'd31;
      e_wdata  = (ph == 1) ? m_wdata : 32'd0;
      e_rv     = (ph == 3);
      e_rpc    = m_rpc;
      e_rvalid = m_prev_gnt;
      e_rdata  = m_rdata;
    end
    chk("flush", {31'd0, flush}, {31'd0, e_bsy});
    chk("busy", {31'd0, busy}, {31'd0, e_bsy});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_rv});
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("mfc0_gnt", {31'd0, mfc0_gnt}, {31'd0, e_gnt});
    chk("mfc0_rvalid", {31'd0, mfc0_rvalid}, {31'd0, e_rvalid});
    chk("mfc0_rdata", mfc0_rdata, e_rdata);
    chk("cp0_raddr", {27'd0, cp0_raddr}, {27'd0, e_raddr});
    chk("cp0_we", {31'd0, cp0_we}, {31'd0, e_we});
    chk("cp0_waddr", {27'd0, cp0_waddr}, {27'd0, e_waddr});
    chk("cp0_wdata", cp0_wdata, e_wdata);
    if (r) begin
      ph = 0; m_rpc = 0; m_rdata = 0; m_prev_gnt = 0;
    end else begin
      m_prev_gnt = e_gnt;
      if (e_gnt) m_rdata = cp0_regs[ra];
      case (ph)
        0: if (ex) begin
             ph = 1;
             m_wdata = bd ? pc - 32'd4 : pc;
           end else if (er) ph = 2;
        1: begin ph = 3; m_rpc = EXV; end
        2: begin ph = 3; m_rpc = cp0_regs[14]; end
        default: if (rdy) ph = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    ph = 0; m_rpc = 0; m_rdata = 0; m_prev_gnt = 0; m_wdata = 0;
    seed = 1; poke = 0; poke_a = 0; poke_d = 0;
    reset = 1; ws_ex = 0; ws_eret = 0; ws_pc = 0; ws_bd = 0;
    mfc0_req = 0; mfc0_raddr = 0; redirect_ready = 1;
    #1;
    step(1, 0, 0, 0, 0, 1, 5'd3, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    seed = 0;
    idle_n(1);

    // plain exception, no delay slot
    step(0, 1, 0, 32'hbfc00100, 0, 0, 0, 1);
    idle_n(3);
    chk("epc_plain", cp0_regs[14], 32'hbfc00100);
    chk("vec_pc", redirect_pc, EXV);

    // delay-slot exception at PC 0 wraps
    step(0, 1, 0, 32'h0, 1, 0, 0, 1);
    idle_n(3);
    chk("epc_wrap", cp0_regs[14], 32'hfffffffc);

    // ERET reads EPC
    poke = 1; poke_a = 5'd14; poke_d = 32'h80001234;
    idle_n(1);
    poke = 0;
    step(0, 0, 1, 0, 0, 0, 0, 1);
    idle_n(3);
    chk("eret_pc", redirect_pc, 32'h80001234);

    // ex and eret together with a pending mfc0
    step(0, 1, 1, 32'h00400010, 0, 1, 5'd12, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1, 5'd12, 1);
    chk("both_epc", cp0_regs[14], 32'h00400010);
    idle_n(1);

    // IF stalls the redirect for 5 cycles
    step(0, 1, 0, 32'h00401000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle_n(2);

    // reset while redirecting, then an mfc0 read of reg 12
    step(0, 1, 0, 32'h00402000, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5'd12, 1);
    idle_n(1);
    chk("mfc0_r12", mfc0_rdata, cp0_regs[12]);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 31)),
           $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
